// File: rtl/mult_defs_pkg.sv
// Shared definitions for the sequential multiplier and its future divider sibling.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package mult_defs;

    // Default operand width used by the MULT/MULTU datapath.
    localparam int DEF_WIDTH = 32;

    // Control states shared by the multicycle arithmetic units.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_mult_negate.sv
// Conditional two's-complement of a wide value (result sign fix-up).
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module seq_mult_negate #(
    parameter int W = 64
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/seq_mult.sv
// Radix-2 shift-add multiplier, signed or unsigned, one multiplier bit per clock.
// Latency: start sampled at edge 0, done high in the cycle after edge WIDTH+1.
// Backpressure: start is only accepted in IDLE; requests while busy are dropped.
module seq_mult
    import mult_defs::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             over
);

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic               neg;
    logic               sgn;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    logic               ovf_nx;

    // Magnitudes of the operands; the most-negative value maps to 2^(WIDTH-1),
    // which is exact as an unsigned number.
    assign mag1 = (is_signed && src1[WIDTH-1]) ? (~src1 + WIDTH'(1)) : src1;
    assign mag2 = (is_signed && src2[WIDTH-1]) ? (~src2 + WIDTH'(1)) : src2;

    // Upper-half add with the carry kept; the multiplier lives in acc_lo and
    // shifts out through bit 0 as the product shifts in from the top.
    assign sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});

    seq_mult_negate #(
        .W (2*WIDTH)
    ) u_negate (
        .val ({acc_hi, acc_lo}),
        .neg (neg),
        .res (prod)
    );

    // Overflow: the product cannot be represented in WIDTH bits of the chosen mode.
    assign ovf_nx = sgn ? (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                        : (prod[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and status decode.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    state_nx = FIN;
                end
            end
            FIN: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Operand capture, shift-add iterations, and result registration on FIN entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            neg    <= 1'b0;
            sgn    <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            over   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= mag1;
                        acc_lo <= mag2;
                        acc_hi <= '0;
                        cnt    <= CNT_W'(WIDTH);
                        neg    <= is_signed & (src1[WIDTH-1] ^ src2[WIDTH-1]);
                        sgn    <= is_signed;
                    end
                end
                RUN: begin
                    if (cnt != '0) begin
                        {acc_hi, acc_lo} <= {sum, acc_lo[WIDTH-1:1]};
                        cnt              <= cnt - CNT_W'(1);
                    end else begin
                        hi   <= prod[2*WIDTH-1:WIDTH];
                        lo   <= prod[WIDTH-1:0];
                        over <= ovf_nx;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
